// File: rtl/grey_scan_if.sv
// Pad-side bundle for grey_scan: counter digits and hold in, segment bus, index,
// frame strobe and error flag out.
interface grey_scan_if;
   logic [59:0] digits;
   logic        hold;
   logic [7:0]  io_out;
   logic [3:0]  dig_idx;
   logic        frame;
   logic        err;

   modport master (output digits, hold, input io_out, dig_idx, frame, err);
   modport slave  (input digits, hold, output io_out, dig_idx, frame, err);
endinterface

// File: rtl/grey_scan.sv
// Snapshots twelve Johnson-coded digits and scans them MSD-first onto a 7-segment bus.
// Define LZB_EN to blank leading zeros.
module grey_scan #(
   parameter int unsigned DWELL = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   grey_scan_if.slave  bus
);

   typedef enum logic {LOAD, SHOW} state_t;

   localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);

   state_t           state;
   logic [11:0][4:0] snap;
   logic [3:0]       idx;
   logic [7:0]       cnt;

   // Returns 4'hF for any of the 22 codes outside the Johnson sequence.
   function automatic logic [3:0] jdecode(input logic [4:0] c);
      case (c)
         5'b00000: return 4'd0;
         5'b00001: return 4'd1;
         5'b00011: return 4'd2;
         5'b00111: return 4'd3;
         5'b01111: return 4'd4;
         5'b11111: return 4'd5;
         5'b11110: return 4'd6;
         5'b11100: return 4'd7;
         5'b11000: return 4'd8;
         5'b10000: return 4'd9;
         default:  return 4'hF;
      endcase
   endfunction

   function automatic logic any_bad(input logic [11:0][4:0] d);
      logic bad;
      bad = 1'b0;
      for (int i = 0; i < 12; i++)
         if (jdecode(d[i]) == 4'hF) bad = 1'b1;
      return bad;
   endfunction

   function automatic logic [6:0] seg7(input logic [3:0] v);
      case (v)
         4'd0:    return 7'h3F;
         4'd1:    return 7'h06;
         4'd2:    return 7'h5B;
         4'd3:    return 7'h4F;
         4'd4:    return 7'h66;
         4'd5:    return 7'h6D;
         4'd6:    return 7'h7D;
         4'd7:    return 7'h07;
         4'd8:    return 7'h7F;
         4'd9:    return 7'h6F;
         default: return 7'h79;
      endcase
   endfunction

   logic [11:0][4:0] next_snap;
   logic [3:0]       cur_val;
   logic             cur_dp;
   logic             blank;

   assign next_snap = bus.hold ? snap : bus.digits;
   assign cur_val   = jdecode(snap[idx]);
   assign cur_dp    = (idx == 4'd9) || (idx == 4'd6) || (idx == 4'd3);

`ifdef LZB_EN
   logic lz;
   assign blank = lz && (cur_val == 4'd0) && (idx != 4'd0);
`else
   assign blank = 1'b0;
`endif

   // Outputs are registered for the cycle being entered: a LOAD edge raises
   // FRAME, each SHOW edge presents the digit at idx for one of its DWELL cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= LOAD;
         // NOTE: the snapshot is reset so a frame shown before any capture is all zeros.
         snap        <= '0;
         idx         <= 4'd11;
         cnt         <= '0;
`ifdef LZB_EN
         lz          <= 1'b1;
`endif
         bus.io_out  <= 8'h00;
         bus.dig_idx <= 4'hF;
         bus.frame   <= 1'b0;
         bus.err     <= 1'b0;
      end else begin
         // NOTE: non-blocking everywhere here so every register sees pre-edge values.
         unique case (state)
            LOAD: begin
               snap        <= next_snap;
               bus.err     <= bus.err | any_bad(next_snap);
               bus.frame   <= 1'b1;
               bus.io_out  <= 8'h00;
               bus.dig_idx <= 4'hF;
               idx         <= 4'd11;
               cnt         <= '0;
`ifdef LZB_EN
               lz          <= 1'b1;
`endif
               state       <= SHOW;
            end
            SHOW: begin
               bus.frame   <= 1'b0;
               bus.dig_idx <= idx;
               bus.io_out  <= blank ? 8'h00 : {cur_dp, seg7(cur_val)};
`ifdef LZB_EN
               if (cur_val != 4'd0) lz <= 1'b0;
`endif
               if (cnt == DWELL_LAST) begin
                  cnt <= '0;
                  if (idx == 4'd0) state <= LOAD;
                  else             idx   <= idx - 4'd1;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_grey_scan.sv
// Scoreboard bench for grey_scan: a driver pushes each frame's expected outputs,
// a monitor pops one entry per cycle; a second DWELL=1 instance checks index order.
module tb_grey_scan;

   localparam int DWELL     = 4;
   localparam int FRAME_LEN = 1 + 12 * DWELL;
`ifdef LZB_EN
   localparam bit LZB = 1'b1;
`else
   localparam bit LZB = 1'b0;
`endif

   typedef struct packed {
      logic       frame;
      logic [3:0] idx;
      logic [7:0] io;
      logic       err;
   } exp_t;

   logic clk;
   logic rst_n;
   grey_scan_if bus ();
   grey_scan_if bus1 ();

   assign bus1.digits = bus.digits;
   assign bus1.hold   = bus.hold;

   grey_scan #(.DWELL(DWELL)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
   grey_scan #(.DWELL(1))     dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int   n_vec = 0;
   int   n_err = 0;
   bit   mon_en = 1'b0;
   exp_t q[$];

   logic [4:0] jc  [10] = '{5'b00000, 5'b00001, 5'b00011, 5'b00111, 5'b01111,
                            5'b11111, 5'b11110, 5'b11100, 5'b11000, 5'b10000};
   logic [6:0] seg [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                            7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

   logic [4:0] m_snap [12];
   bit         m_err;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int decode(input logic [4:0] c);
      for (int v = 0; v < 10; v++)
         if (jc[v] == c) return v;
      return -1;
   endfunction

   function automatic logic [59:0] encode(input longint n);
      logic [59:0] d;
      longint      r;
      r = n;
      for (int i = 0; i < 12; i++) begin
         d[i*5 +: 5] = jc[int'(r % 10)];
         r = r / 10;
      end
      return d;
   endfunction

   function automatic logic [59:0] rand_digits();
      logic [59:0] d;
      int          top;
      top = $urandom_range(0, 12);
      for (int i = 0; i < 12; i++) begin
         if (i >= top)                     d[i*5 +: 5] = jc[0];
         else if ($urandom_range(0, 15) == 0) d[i*5 +: 5] = 5'($urandom);
         else                              d[i*5 +: 5] = jc[$urandom_range(0, 9)];
      end
      return d;
   endfunction

   // Leading-zero rule stated directly: a zero is blank when every digit above it is a valid zero.
   function automatic bit is_blank(input int i);
      if (!LZB || i == 0 || decode(m_snap[i]) != 0) return 1'b0;
      for (int j = i + 1; j < 12; j++)
         if (decode(m_snap[j]) != 0) return 1'b0;
      return 1'b1;
   endfunction

   // Drives one frame starting at the negedge before its LOAD edge; returns at the
   // negedge before the next LOAD edge, or early after abort_at negedges.
   task automatic run_frame(input logic [59:0] d, input logic h, input int abort_at);
      exp_t e;
      int   v;
      bus.digits = d;
      bus.hold   = h;
      if (!h)
         for (int i = 0; i < 12; i++) m_snap[i] = d[i*5 +: 5];
      for (int i = 0; i < 12; i++)
         if (decode(m_snap[i]) < 0) m_err = 1'b1;
      e.frame = 1'b1; e.idx = 4'hF; e.io = 8'h00; e.err = m_err;
      q.push_back(e);
      for (int i = 11; i >= 0; i--) begin
         v       = decode(m_snap[i]);
         e.frame = 1'b0;
         e.idx   = 4'(i);
         if (is_blank(i)) e.io = 8'h00;
         else e.io = {(i == 9 || i == 6 || i == 3), (v < 0) ? 7'h79 : seg[v]};
         repeat (DWELL) q.push_back(e);
      end
      for (int k = 1; k <= FRAME_LEN; k++) begin
         @(negedge clk);
         if (abort_at != 0 && k == abort_at) return;
         if (k == FRAME_LEN / 2) begin
            bus.digits = {28'($urandom), $urandom};
            bus.hold   = 1'($urandom);
         end
      end
   endtask

   // Monitor: one expected entry per cycle while a frame is in flight.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (mon_en) begin
            if (q.size() == 0) begin
               check("queue_underflow", 32'd1, 32'd0);
            end else begin
               e = q.pop_front();
               check("frame",   bus.frame,   e.frame);
               check("dig_idx", bus.dig_idx, e.idx);
               check($sformatf("io_out[idx %0d]", e.idx), bus.io_out, e.io);
               check("err",     bus.err,     e.err);
            end
         end
      end
   end

   // DWELL=1 instance: the index walks F,11..0 and repeats every 13 cycles.
   initial begin
      int k;
      k = 0;
      forever begin
         @(posedge clk);
         #1;
         if (!rst_n) begin
            k = 0;
         end else begin
            check("d1_dig_idx", bus1.dig_idx, (k % 13 == 0) ? 32'hF : 32'(12 - k % 13));
            check("d1_frame",   bus1.frame,   (k % 13 == 0) ? 32'd1 : 32'd0);
            k++;
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      logic [59:0] d;
      rst_n      = 1'b0;
      bus.digits = '0;
      bus.hold   = 1'b0;
      m_err      = 1'b0;
      for (int i = 0; i < 12; i++) m_snap[i] = 5'b00000;
      repeat (3) @(negedge clk);
      check("rst_io_out",  bus.io_out,   32'h00);
      check("rst_dig_idx", bus.dig_idx,  32'hF);
      check("rst_frame",   bus.frame,    32'd0);
      check("rst_err",     bus.err,      32'd0);
      check("rst_d1_idx",  bus1.dig_idx, 32'hF);

      rst_n  = 1'b1;
      mon_en = 1'b1;
      run_frame(encode(0), 1'b0, 0);
      run_frame(encode(1234567890), 1'b0, 0);
      d = encode(0);
      d[9:5] = 5'b00101;
      run_frame(d, 1'b0, 0);
      run_frame(encode(42), 1'b0, 0);

      // Reset mid-SHOW while index 6 is on the bus; ERR is set at this point.
      run_frame(encode(1234567890), 1'b0, 22);
      rst_n  = 1'b0;
      mon_en = 1'b0;
      q.delete();
      m_err  = 1'b0;
      for (int i = 0; i < 12; i++) m_snap[i] = 5'b00000;
      #1;
      check("midrst_io_out",  bus.io_out,  32'h00);
      check("midrst_dig_idx", bus.dig_idx, 32'hF);
      check("midrst_frame",   bus.frame,   32'd0);
      check("midrst_err",     bus.err,     32'd0);
      repeat (2) @(negedge clk);
      rst_n  = 1'b1;
      mon_en = 1'b1;

      run_frame(encode(5), 1'b0, 0);
      run_frame(encode(7), 1'b1, 0);
      run_frame(encode(7), 1'b0, 0);

      for (int f = 0; f < 24; f++)
         run_frame(rand_digits(), ($urandom_range(0, 3) == 0), 0);

      mon_en = 1'b0;
      check("queue_drained", q.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/grey_scan.md
# grey_scan

Display scanner directly downstream of the 12-digit Gray-coded decimal counter. It snapshots the counter's twelve 5-bit Johnson-coded digits and decodes them to 7-segment patterns. It then time-multiplexes the digits, most significant first, onto the 8-bit output pad bus with a digit index. Invalid digit codes are flagged, and leading zeros are optionally blanked.

## Interface
- DWELL, 4: clock cycles each digit is held on IO_OUT; legal range 1..255.
- CLK  input  1  rising-edge clock.
- RST  input  1  asynchronous, active-low reset.
- DIGITS  input  60  counter digits, 5 bits each. [4:0]=ones, [9:5]=tens, … [59:55]=hundred-billions.
- HOLD  input  1  when 1, the next snapshot is skipped and the previous snapshot is kept.
- IO_OUT  output  8  {DP, g, f, e, d, c, b, a}, active high.
- DIG_IDX  output  4  digit currently on IO_OUT: 11=hundred-billions … 0=ones; 4'hF when no digit is shown.
- FRAME  output  1  one-cycle pulse marking the snapshot cycle.
- ERR  output  1  sticky flag for an invalid digit code.

## Operation
- Johnson decode (code → value): 00000→0, 00001→1, 00011→2, 00111→3, 01111→4, 11111→5, 11110→6, 11100→7, 11000→8, 10000→9. The other 22 codes are invalid.
- Segment map: 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F, invalid=0x79 ('E'), blank=0x00.
- FSM with two states, LOAD and SHOW.
- LOAD (1 cycle):
  - FRAME=1, IO_OUT=0x00, DIG_IDX=4'hF.
  - The snapshot register captures DIGITS unless HOLD=1.
  - If any captured digit is invalid, ERR is set.
  - The leading-zero flag is set to 1.
  - Next state is SHOW with index 11.
- SHOW:
  - Each index is held for DWELL cycles, stepping down 11→0. After index 0's last cycle the FSM returns to LOAD.
  - IO_OUT[6:0] carries the decoded snapshot digit at DIG_IDX.
  - IO_OUT[7] (DP) is 1 at indices 9, 6 and 3 (billions, millions, thousands), unless that digit is blanked.
- ERR clears only on reset. HOLD never affects ERR.
- Snapshot digits never change during SHOW, so the display of a frame is coherent.

## Timing
- Reset values (asserted asynchronously, immediately):
  - state=LOAD, snapshot all 00000, dwell count 0, leading-zero flag 1.
  - IO_OUT=0x00, DIG_IDX=4'hF, FRAME=0, ERR=0.
- FRAME is 0 during reset. It first pulses in the first cycle after RST deasserts; that cycle is LOAD.
- All outputs are registered. IO_OUT and DIG_IDX change together on the same edge, with no intermediate values.
- Frame length is 1 + 12·DWELL cycles, so FRAME has that period.
- Snapshot latency: DIGITS sampled at the LOAD edge appear at index 11 on the following cycle.
- HOLD is sampled only at the LOAD edge; it is ignored during SHOW.
- Reset asserted mid-frame: outputs go to reset values at once, and the frame restarts from LOAD after release.
- DWELL=1: the index changes every cycle and the frame is 13 cycles.

## Configuration
- LZB_EN defined:
  - Leading-zero blanking is enabled. A valid zero digit is shown as 0x00 with DP=0 while the leading-zero flag is 1.
  - The first nonzero or invalid digit clears the flag for the rest of the frame.
  - Index 0 is never blanked.
- LZB_EN undefined:
  - Every digit shows its pattern, zeros included.
  - The leading-zero flag logic is absent.

## Test plan
- Reset, then DIGITS all 00000 with LZB_EN, DWELL=4 → FRAME pulses every 49 cycles. Indices 11..1 give IO_OUT=0x00, index 0 gives 0x3F. Without LZB_EN, index 9 gives 0xBF.
- DIGITS = 1,234,567,890 (Johnson-coded), LZB_EN → indices 11..10 blank. Index 9 gives 0x86. Then 0x5B, 0x4F, 0xE6 (idx 6), 0x6D, 0x7D, 0x87 (idx 3), 0x7F, 0x6F, 0x3F.
- Tens digit = 00101 (invalid) → at index 1, IO_OUT=0x79. ERR=1 after that LOAD and stays 1 once DIGITS becomes valid again, until RST=0.
- HOLD=1 across a LOAD while DIGITS changes from 5 to 7 in the ones digit → next frame index 0 still shows 0x6D. With HOLD=0 at the following LOAD → 0x07.
- RST pulled low mid-SHOW at index 6 → IO_OUT=0x00, DIG_IDX=4'hF, ERR=0 immediately. After release, FRAME pulses in the next cycle.
- DWELL=1 → DIG_IDX sequence F,11,10,…,0,F repeats every 13 cycles.
